// File: rtl/barcode_led_pkg.sv
// Shared definitions for the barcode scanner LED sequencer: register map,
// CTRL field layout, display modes, sequencer states and flash patterns.
package barcode_led_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_WIDTH      = 4;
   localparam int CTRL_MODE_LSB   = 0;
   localparam int CTRL_EN_BIT     = 2;
   localparam int CTRL_EVT_EN_BIT = 3;

   typedef enum logic [1:0] {
      MODE_STATIC  = 2'd0,
      MODE_BLINK   = 2'd1,
      MODE_CHASE_L = 2'd2,
      MODE_CHASE_R = 2'd3
   } led_mode_t;

   typedef enum logic {
      ST_PATTERN = 1'b0,
      ST_FLASH   = 1'b1
   } seq_state_t;

   localparam logic [7:0] FLASH_GOOD  = 8'hFF;
   localparam logic [7:0] FLASH_ERR_A = 8'h55;
   localparam logic [7:0] FLASH_ERR_B = 8'hAA;

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running tick generator: one-cycle tick every period+1 cycles while run
// is high; restart or a stopped run forces the count back to zero.
module led_tick_prescaler #(
   parameter int PRESCALE_WIDTH = 24
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      run,
   input  logic                      restart,
   input  logic [PRESCALE_WIDTH-1:0] period,
   output logic                      tick
);

   logic [PRESCALE_WIDTH-1:0] count;

   assign tick = run & (count == period);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (!run || restart || tick) begin
         count <= '0;
      end else begin
         count <= count + PRESCALE_WIDTH'(1);
      end
   end

endmodule

// File: rtl/barcode_led_sequencer.sv
// Avalon-MM LED sequencer: static/blink/chase patterns on a programmable tick,
// with a hardware flash override on decoder good-scan / scan-error events.
module barcode_led_sequencer
   import barcode_led_pkg::*;
#(
   parameter int LED_WIDTH      = 8,
   parameter int PRESCALE_WIDTH = 24,
   parameter int DEFAULT_PERIOD = 12499999,
   parameter int FLASH_TICKS    = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   input  logic                 scan_evt,
   input  logic                 scan_err,
   output logic [LED_WIDTH-1:0] led_out
);

   localparam int FLASH_CNT_W = $clog2(FLASH_TICKS + 1);
   localparam logic [FLASH_CNT_W-1:0] FLASH_LOAD = FLASH_CNT_W'(FLASH_TICKS);

   logic [LED_WIDTH-1:0]      data;
   logic [CTRL_WIDTH-1:0]     ctrl;
   logic [PRESCALE_WIDTH-1:0] period;
   logic                      err_seen;
   logic [7:0]                good_cnt;

   seq_state_t                state;
   logic                      flash_is_err;
   logic                      flash_alt;
   logic [FLASH_CNT_W-1:0]    flash_cnt;
   logic                      phase;
   logic [LED_WIDTH-1:0]      shift_reg;
   logic [LED_WIDTH-1:0]      led_next;

   logic      wr, wr_data, wr_ctrl, wr_period, wr_status;
   logic      enable, evt_en, flash_active, flash_start, tick;
   led_mode_t mode;
   logic      unused_wdata;

   assign wr        = chipselect & ~write_n;
   assign wr_data   = wr & (address == ADDR_DATA);
   assign wr_ctrl   = wr & (address == ADDR_CTRL);
   assign wr_period = wr & (address == ADDR_PERIOD);
   assign wr_status = wr & (address == ADDR_STATUS);

   assign mode         = led_mode_t'(ctrl[CTRL_MODE_LSB +: 2]);
   assign enable       = ctrl[CTRL_EN_BIT];
   assign evt_en       = ctrl[CTRL_EVT_EN_BIT];
   assign flash_active = (state == ST_FLASH);
   assign flash_start  = evt_en & (scan_evt | scan_err);

   assign unused_wdata = &{1'b0, writedata};

   // Counting continues through a flash even with the pattern disabled, so the
   // override always times out.
   led_tick_prescaler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (enable | flash_active),
      .restart (wr_period | flash_start),
      .period  (period),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data     <= '0;
         ctrl     <= '0;
         period   <= PRESCALE_WIDTH'(DEFAULT_PERIOD);
         err_seen <= 1'b0;
         good_cnt <= 8'd0;
      end else begin
         if (wr_data)   data   <= writedata[LED_WIDTH-1:0];
         if (wr_ctrl)   ctrl   <= writedata[CTRL_WIDTH-1:0];
         if (wr_period) period <= writedata[PRESCALE_WIDTH-1:0];
         // A clear coinciding with an event still records that event.
         good_cnt <= (wr_status ? 8'd0 : good_cnt) + {7'd0, scan_evt};
         err_seen <= (wr_status ? 1'b0 : err_seen) | scan_err;
      end
   end

   always_comb begin
      led_next = data;
      if (flash_active) begin
         if (flash_is_err) begin
            led_next = flash_alt ? LED_WIDTH'(FLASH_ERR_B) : LED_WIDTH'(FLASH_ERR_A);
         end else begin
            led_next = LED_WIDTH'(FLASH_GOOD);
         end
      end else if (enable) begin
         case (mode)
            MODE_BLINK:   led_next = phase ? data : '0;
            MODE_CHASE_L,
            MODE_CHASE_R: led_next = shift_reg;
            default:      led_next = data;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_PATTERN;
         flash_is_err <= 1'b0;
         flash_alt    <= 1'b0;
         flash_cnt    <= '0;
         phase        <= 1'b0;
         shift_reg    <= '0;
         led_out      <= '0;
      end else begin
         led_out <= led_next;

         // Register writes reload the pattern even mid-flash; ticks only
         // advance it outside a flash.
         if (wr_data) begin
            phase     <= 1'b1;
            shift_reg <= writedata[LED_WIDTH-1:0];
         end else if (wr_ctrl) begin
            phase     <= 1'b1;
            shift_reg <= data;
         end else if (!flash_active && tick) begin
            case (mode)
               MODE_BLINK:   phase     <= ~phase;
               MODE_CHASE_L: shift_reg <= {shift_reg[LED_WIDTH-2:0], shift_reg[LED_WIDTH-1]};
               MODE_CHASE_R: shift_reg <= {shift_reg[0], shift_reg[LED_WIDTH-1:1]};
               default:      ;
            endcase
         end

         case (state)
            ST_PATTERN: begin
               if (flash_start) begin
                  state        <= ST_FLASH;
                  flash_is_err <= scan_err;
                  flash_cnt    <= FLASH_LOAD;
                  flash_alt    <= 1'b0;
               end
            end
            ST_FLASH: begin
               if (flash_start) begin
                  flash_is_err <= scan_err;
                  flash_cnt    <= FLASH_LOAD;
                  flash_alt    <= 1'b0;
               end else if (tick) begin
                  flash_alt <= ~flash_alt;
                  if (flash_cnt <= FLASH_CNT_W'(1)) begin
                     flash_cnt <= '0;
                     state     <= ST_PATTERN;
                  end else begin
                     flash_cnt <= flash_cnt - FLASH_CNT_W'(1);
                  end
               end
            end
            default: state <= ST_PATTERN;
         endcase
      end
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         ADDR_DATA:   readdata = 32'(data);
         ADDR_CTRL:   readdata = 32'(ctrl);
         ADDR_PERIOD: readdata = 32'(period);
         ADDR_STATUS: readdata = {16'd0, good_cnt, 5'd0, err_seen,
                                  flash_active & flash_is_err, flash_active};
         default:     readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_barcode_led_sequencer.sv
// Bench for barcode_led_sequencer: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the LED/register rules.
module tb_barcode_led_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        scan_evt = 1'b0;
   logic        scan_err = 1'b0;
   logic [7:0]  led_out;

   int nvec = 0;
   int nerr = 0;

   barcode_led_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .scan_evt   (scan_evt),
      .scan_err   (scan_err),
      .led_out    (led_out)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   int m_data, m_ctrl, m_period, m_good, m_cnt, m_shift, m_left, m_done;
   bit m_err_seen, m_flash, m_flash_err, m_phase;
   int m_led;
   int n_data, n_ctrl, n_period, n_good, n_cnt, n_shift, n_left, n_done, n_led;
   bit n_err_seen, n_flash, n_flash_err, n_phase;

   task automatic model_reset();
      m_data = 0; m_ctrl = 0; m_period = 12499999; m_good = 0; m_cnt = 0;
      m_shift = 0; m_left = 0; m_done = 0; m_err_seen = 0; m_flash = 0;
      m_flash_err = 0; m_phase = 0; m_led = 0;
   endtask

   function automatic int model_led();
      int mode;
      mode = m_ctrl % 4;
      if (m_flash) return m_flash_err ? ((m_done % 2 == 0) ? 'h55 : 'hAA) : 'hFF;
      if ((m_ctrl / 4) % 2 == 0 || mode == 0) return m_data;
      if (mode == 1) return m_phase ? m_data : 0;
      return m_shift;
   endfunction

   function automatic logic [31:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0: return 32'(m_data);
         2'd1: return 32'(m_ctrl);
         2'd2: return 32'(m_period);
         default: return 32'(m_good * 256 + (m_err_seen ? 4 : 0) +
                             ((m_flash && m_flash_err) ? 2 : 0) + (m_flash ? 1 : 0));
      endcase
   endfunction

   task automatic model_eval();
      bit wr, en, run, tick, evt;
      int mode;
      wr   = chipselect && !write_n;
      en   = ((m_ctrl / 4) % 2) == 1;
      mode = m_ctrl % 4;
      run  = en || m_flash;
      tick = run && (m_cnt == m_period);
      evt  = ((m_ctrl / 8) % 2 == 1) && (scan_evt || scan_err);
      n_led = model_led();
      n_cnt = (!run || evt || (wr && address == 2) || tick) ? 0 : m_cnt + 1;
      n_phase = m_phase; n_shift = m_shift;
      if (wr && address == 0) begin
         n_phase = 1; n_shift = int'(writedata[7:0]);
      end else if (wr && address == 1) begin
         n_phase = 1; n_shift = m_data;
      end else if (!m_flash && tick) begin
         if (mode == 1) n_phase = !m_phase;
         if (mode == 2) n_shift = (m_shift * 2 + m_shift / 128) % 256;
         if (mode == 3) n_shift = m_shift / 2 + (m_shift % 2) * 128;
      end
      n_flash = m_flash; n_flash_err = m_flash_err; n_left = m_left; n_done = m_done;
      if (evt) begin
         n_flash = 1; n_flash_err = scan_err; n_left = 4; n_done = 0;
      end else if (m_flash && tick) begin
         n_done = m_done + 1; n_left = m_left - 1;
         if (n_left == 0) n_flash = 0;
      end
      n_data   = (wr && address == 0) ? int'(writedata[7:0]) : m_data;
      n_ctrl   = (wr && address == 1) ? int'(writedata[3:0]) : m_ctrl;
      n_period = (wr && address == 2) ? int'(writedata[23:0]) : m_period;
      n_good   = (((wr && address == 3) ? 0 : m_good) + (scan_evt ? 1 : 0)) % 256;
      n_err_seen = ((wr && address == 3) ? 1'b0 : m_err_seen) | scan_err;
   endtask

   task automatic model_commit();
      m_data = n_data; m_ctrl = n_ctrl; m_period = n_period; m_good = n_good;
      m_cnt = n_cnt; m_shift = n_shift; m_left = n_left; m_done = n_done;
      m_err_seen = n_err_seen; m_flash = n_flash; m_flash_err = n_flash_err;
      m_phase = n_phase; m_led = n_led;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      model_eval();
      @(posedge clk);
      model_commit();
      #1;
      check("led", {24'd0, led_out}, 32'(m_led));
      check("rd", readdata, model_rd(address));
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] v);
      address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
      step();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   logic [7:0] exp_seq [4];
   int nff;

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state
      check("rst_led", {24'd0, led_out}, 32'h0);
      address = 2'd0; #1 check("rst_data", readdata, 32'd0);
      address = 2'd1; #1 check("rst_ctrl", readdata, 32'd0);
      address = 2'd2; #1 check("rst_period", readdata, 32'd12499999);
      address = 2'd3; #1 check("rst_status", readdata, 32'd0);

      // Static pattern, one-cycle latency
      wr_reg(2'd0, 32'hA5);
      wr_reg(2'd1, 32'h0);
      check("static_led", {24'd0, led_out}, 32'hA5);
      repeat (3) begin
         scan_evt = 1'b1; step(); scan_evt = 1'b0; step();
      end
      address = 2'd3; #1;
      check("good_cnt3", readdata & 32'hFF00, 32'h0300);
      check("static_hold", {24'd0, led_out}, 32'hA5);

      // Chase left
      wr_reg(2'd2, 32'd3);
      wr_reg(2'd0, 32'h81);
      wr_reg(2'd1, 32'h6);
      exp_seq = '{8'h81, 8'h03, 8'h06, 8'h0C};
      for (int i = 1; i <= 13; i++) begin
         step();
         if (i % 4 == 1) check("chase_l", {24'd0, led_out}, {24'd0, exp_seq[i / 4]});
      end

      // Blink
      wr_reg(2'd1, 32'h0);
      wr_reg(2'd1, 32'h5);
      exp_seq = '{8'h81, 8'h00, 8'h81, 8'h00};
      for (int i = 1; i <= 13; i++) begin
         step();
         if (i % 4 == 1) check("blink", {24'd0, led_out}, {24'd0, exp_seq[i / 4]});
      end

      // Good-scan flash over a chase parked at 0x06
      wr_reg(2'd1, 32'h0);
      wr_reg(2'd1, 32'hE);
      repeat (9) step();
      check("chase_06", {24'd0, led_out}, 32'h06);
      address = 2'd3;
      scan_evt = 1'b1; step(); scan_evt = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         check("flash_good", {24'd0, led_out}, 32'hFF);
         if (i == 8) check("flash_active", readdata & 32'hFF07, 32'h0401);
      end
      step();
      check("resume_06", {24'd0, led_out}, 32'h06);

      // Error wins on simultaneous pulses; 0x55/0xAA alternation
      scan_evt = 1'b1; scan_err = 1'b1; step(); scan_evt = 1'b0; scan_err = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step();
         check("flash_err", {24'd0, led_out}, (i <= 4) ? 32'h55 : 32'hAA);
      end
      check("err_status", readdata & 32'hFF07, 32'h0507);

      // Good event mid-flash restarts a full good flash
      scan_evt = 1'b1; step(); scan_evt = 1'b0;
      nff = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (led_out !== 8'hFF) break;
         nff++;
      end
      check("restart_len", 32'(nff), 32'd16);

      // Status clear coinciding with a good scan
      address = 2'd3; writedata = 32'hFFFF_FFFF; chipselect = 1'b1; write_n = 1'b0;
      scan_evt = 1'b1;
      step();
      chipselect = 1'b0; write_n = 1'b1; scan_evt = 1'b0;
      check("clr_evt", readdata & 32'hFF04, 32'h0100);

      // Asynchronous reset during a flash
      step(); step();
      check("pre_rst_flash", {24'd0, led_out}, 32'hFF);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_led", {24'd0, led_out}, 32'h0);
      check("async_rst_status", readdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      address = 2'd1; #1 check("post_rst_ctrl", readdata, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         address    = 2'($urandom_range(0, 3));
         chipselect = ($urandom_range(0, 3) != 0);
         write_n    = ($urandom_range(0, 4) != 0);
         writedata  = $urandom;
         if (address == 2'd2) writedata = (writedata & 32'hFF00_0000) | 32'($urandom_range(0, 3));
         scan_evt   = ($urandom_range(0, 19) == 0);
         scan_err   = ($urandom_range(0, 29) == 0);
         step();
      end
      chipselect = 1'b0; write_n = 1'b1; scan_evt = 1'b0; scan_err = 1'b0;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/barcode_led_sequencer.md
Name: barcode_led_sequencer

Overview:
Avalon-MM slave that owns the scanner board's 8 LEDs and sequences them autonomously instead of relying on Nios software bit-banging a plain output port. It provides static, blink and chase patterns timed by a programmable prescaler. It also runs a hardware "flash" override on good-scan or scan-error events from the barcode decoder, and counts good scans. Sits on the Nios data master next to the other PIO peripherals; led_out goes to the board LED pins.

Parameters:
LED_WIDTH, 8, number of LEDs driven
PRESCALE_WIDTH, 24, width of PERIOD register and prescaler counter
DEFAULT_PERIOD, 12499999, PERIOD reset value (tick every 0.25 s at 50 MHz)
FLASH_TICKS, 4, number of ticks a flash override lasts

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  2  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address, zero wait states
scan_evt  in  1  one-cycle pulse: decoder produced a good read
scan_err  in  1  one-cycle pulse: decoder failed/checksum error
led_out  out  LED_WIDTH  registered LED drive, 1 = LED on

Behaviour:
- Write = chipselect & ~write_n. Unused bits read 0. Reset: DATA=0, CTRL=0, PERIOD=DEFAULT_PERIOD, STATUS=0, led_out=0, state PATTERN.
- addr 0 DATA R/W [7:0] base pattern.
- addr 1 CTRL R/W [1:0] mode (0 STATIC, 1 BLINK, 2 CHASE_L, 3 CHASE_R), [2] enable, [3] evt_en.
- addr 2 PERIOD R/W [PRESCALE_WIDTH-1:0]; tick every PERIOD+1 cycles; PERIOD=0 gives a tick every cycle.
- addr 3 STATUS R: [0] flash_active, [1] flash_is_err, [2] err_seen, [15:8] good_cnt. Write of any value clears err_seen and good_cnt.
- Prescaler: counter runs while (enable | flash_active); tick is a one-cycle pulse when counter==PERIOD, then counter returns to 0. Counter held at 0 otherwise. Any write to PERIOD, or entry into FLASH, zeroes the counter.
- Pattern generator (state PATTERN):
  - enable=0 or STATIC: next led = DATA.
  - BLINK: phase bit toggles on each tick; led = phase ? DATA : 0. Phase set to 1 on any CTRL or DATA write.
  - CHASE_L/CHASE_R: shift reg rotates left/right by 1 on each tick; led = shift reg. Shift reg is reloaded from DATA on any CTRL or DATA write. DATA=0 gives a constant 0.
- FSM states: PATTERN, FLASH.
  - PATTERN->FLASH when evt_en & (scan_evt | scan_err). flash_is_err = scan_err (err wins on simultaneous pulses). flash_cnt = FLASH_TICKS.
  - FLASH output: good = all ones; err = 0x55 and 0xAA alternating on each tick, starting at 0x55.
  - FLASH: flash_cnt decrements on each tick; when it reaches 0 on a tick, go to PATTERN on the next edge.
  - A new event during FLASH restarts flash_cnt, updates flash_is_err and zeroes the prescaler.
  - Phase and shift reg are frozen during FLASH and resume unchanged afterwards. CTRL/DATA writes during FLASH still update the registers and perform the reload.
- good_cnt increments (8-bit wrap) on every scan_evt regardless of evt_en. err_seen is set on scan_err. A STATUS clear in the same cycle as an event yields the post-event value: good_cnt=1 / err_seen=1.
- Latency: led_out is registered. A write accepted at edge k updates registers at k; led_out reflects it at edge k+1. Tick-driven changes likewise appear one cycle after the tick.
- Reset mid-flash or mid-chase: immediate return to reset values.

Decomposition:
- Package barcode_led_pkg holds:
  - register address constants (ADDR_DATA=0, ADDR_CTRL=1, ADDR_PERIOD=2, ADDR_STATUS=3)
  - mode encodings
  - CTRL bit indices
  - FSM state enum
  - flash pattern constants (all ones, 0x55, 0xAA)
- One sub-module: led_tick_prescaler, with inputs run, restart, period and output tick.

Test Plan:
- Reset, then read all 4 addresses -> DATA=0, CTRL=0, PERIOD=12499999, STATUS=0; led_out=0x00.
- DATA=0xA5, CTRL=0x0 -> led_out=0xA5 exactly 1 cycle after the write edge. Set CTRL=0x0 (enable=0), pulse scan_evt 3 times -> STATUS[15:8]=3, led_out unchanged.
- PERIOD=3, DATA=0x81, CTRL=0x6 (CHASE_L, en) -> led_out 0x81, 0x03, 0x06, 0x0C on successive ticks every 4 cycles. Repeat with CTRL=0x5 (BLINK) -> led_out alternates 0x81/0x00.
- PERIOD=3, CTRL=0xE, chase at 0x06, pulse scan_evt -> led_out=0xFF for 4 ticks (16 cycles), STATUS[0]=1, then resumes at 0x06.
- Simultaneous scan_evt+scan_err with evt_en -> err flash 0x55,0xAA,0x55,0xAA; STATUS[1]=1, [2]=1, good_cnt+1. A second scan_evt mid-flash -> switches to 0xFF and restarts the 4-tick count.
- STATUS write in same cycle as scan_evt -> good_cnt=1, err_seen=0. Assert reset_n mid-flash -> led_out=0 asynchronously, FSM in PATTERN.
